hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard unit for the decode stage. It keeps a per-register scoreboard of outstanding long-latency results (loads, mul/div) and stalls the instruction in ID on RAW hazards, optional WAW hazards, and branch/jalr operands still in EX. It also carries a saturating stall-cycle counter and a stall watchdog. It drives the IF/ID hold and the ID/EX bubble.

## Interface
- NREG, 32, number of architectural registers; register 0 is hard-wired and never pending
- AW, $clog2(NREG), register-index width
- WAW_EN, 1, when 1, also stall on a write to a register that is still pending
- CW, 16, stall-counter width
- TIMEOUT, 1024, consecutive stall cycles before `timeout_err` is set; range 1..2^CW-1

Ports (name, direction, width, meaning):
- clk  in  1  clock; all state updates on the rising edge
- Rst  in  1  synchronous reset, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  AW  ID source indices
- id_use_rs1, id_use_rs2  in  1  the ID instruction reads that source (decoder-provided; immediates and jalr clear `use_rs2`)
- id_rd  in  AW  ID destination index
- id_regwrite  in  1  the ID instruction writes `id_rd`
- id_long  in  1  the ID instruction is long-latency (load, mul, div)
- id_branch  in  1  branch or jalr that resolves in ID
- ex_rd  in  AW  destination of the instruction in EX
- ex_regwrite  in  1  the EX instruction writes `ex_rd` and is short-latency
- done_valid  in  1  a long-latency result is available for forwarding this cycle
- done_rd  in  AW  register index of that result
- flush  in  1  kill the ID instruction this cycle (redirect)
- hz  out  1  stall: hold PC and IF/ID, insert a bubble into ID/EX
- stall_cnt  out  CW  saturating count of cycles with `hz`=1
- timeout_err  out  1  sticky watchdog flag

## Operation
- State: `pend[NREG-1:0]`, `run` (consecutive-stall counter, CW bits), `stall_cnt`, `timeout_err`.
- Forwarded-done mask: `fwd(r)` = `done_valid` && `done_rd`==r && r!=0. A result completing this cycle resolves a hazard in the same cycle, through the existing forwarding path.
- `busy(r)` = `pend[r]` && !`fwd(r)` && r!=0.
- RAW term = (`id_use_rs1` && `busy(id_rs1)`) || (`id_use_rs2` && `busy(id_rs2)`).
- WAW term = `WAW_EN` && `id_regwrite` && `busy(id_rd)`.
- BR term = `id_branch` && `ex_regwrite` && `ex_rd`!=0 && ((`id_use_rs1` && `ex_rd`==`id_rs1`) || (`id_use_rs2` && `ex_rd`==`id_rs2`)).
- `hz` = `id_valid` && !`flush` && !`Rst` && (RAW || WAW || BR). This is combinational from the inputs and registered `pend`.
- Issue = `id_valid` && !`hz` && !`flush`.
- Set condition: issue && `id_regwrite` && `id_long` && `id_rd`!=0 sets `pend[id_rd]`.
- Clear condition: `done_valid` clears `pend[done_rd]`.
- Set and clear on the same index in the same cycle: set wins, because it is a newer producer.
- Clear of a non-pending register: no effect. `pend[0]` is held at 0.
- `stall_cnt` increments on every cycle with `hz`=1 and saturates at 2^CW-1.
- `run` increments while `hz`=1, resets to 0 on any cycle with `hz`=0, and saturates.
- When `run` reaches TIMEOUT, `timeout_err` is set and held until `Rst`.
- `flush` never clears `pend`: long operations already issued still complete.

## Timing
- Reset (`Rst`=1 at an edge): `pend`=0, `run`=0, `stall_cnt`=0, `timeout_err`=0. `hz`=0 while `Rst` is high.
- `hz` has zero latency, valid in the same cycle as the ID inputs.
- A pending bit is visible to the ID instruction one cycle after issue, so a back-to-back consumer of a load stalls in the cycle the load sits in EX.
- Load-use with `done_valid` two cycles after issue gives exactly 1 stall cycle: the consumer stalls for 1 cycle and issues in the cycle `done_valid` is seen.
- BR stall lasts exactly 1 cycle per EX producer, because the producer leaves EX the next cycle.
- `timeout_err` rises on the edge where `run` becomes TIMEOUT, i.e. after TIMEOUT consecutive stall cycles.
- `Rst` mid-stall: the next cycle has all state cleared and `hz`=0. Any outstanding `done_valid` after reset is harmless, because it only clears bits.

## Test plan
- Load-use: issue lw x5 (`id_long`=1), next ID reads x5 with `use_rs1`=1, `done_valid`/`done_rd`=5 one cycle later → `hz`=1 for 1 cycle, then issue; `pend[5]`=0 afterwards; `stall_cnt`=1.
- Same-cycle forward: `pend[7]`=1, ID reads x7, `done_valid` with `done_rd`=7 in the same cycle → `hz`=0; x0 as source or destination never stalls.
- Branch: `ex_regwrite`=1, `ex_rd`=3, ID beq reads x3 → `hz`=1 for exactly 1 cycle; the same case with `id_branch`=0 → `hz`=0.
- WAW: `pend[9]`=1, ID add writes x9 → `hz`=1 with WAW_EN=1 and `hz`=0 with WAW_EN=0; set and clear on x9 in the same cycle leaves `pend[9]`=1.
- Watchdog/saturation: TIMEOUT=8, CW=4, hold a RAW stall for 20 cycles → `timeout_err` rises after cycle 8 and stays high; `stall_cnt` stops at 15.
- Flush/reset: `flush`=1 during a RAW stall → `hz`=0, no issue, `pend` unchanged; `Rst` pulse → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: per-register scoreboard of outstanding long-latency
// results, RAW/WAW/branch-operand stall generation, stall counter and watchdog.
module hazard_scoreboard #(
    parameter int NREG    = 32,
    parameter int AW      = $clog2(NREG),
    parameter bit WAW_EN  = 1'b1,
    parameter int CW      = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          Rst,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs1,
    input  logic [AW-1:0] id_rs2,
    input  logic          id_use_rs1,
    input  logic          id_use_rs2,
    input  logic [AW-1:0] id_rd,
    input  logic          id_regwrite,
    input  logic          id_long,
    input  logic          id_branch,
    input  logic [AW-1:0] ex_rd,
    input  logic          ex_regwrite,
    input  logic          done_valid,
    input  logic [AW-1:0] done_rd,
    input  logic          flush,
    output logic          hz,
    output logic [CW-1:0] stall_cnt,
    output logic          timeout_err
);

    localparam logic [CW-1:0]   CNT_MAX = '1;
    localparam logic [CW-1:0]   TO_VAL  = CW'(TIMEOUT);
    localparam logic [NREG-1:0] R0_MASK = {{(NREG-1){1'b1}}, 1'b0};

    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_next;
    logic [NREG-1:0] fwd_mask;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic [CW-1:0]   run;
    logic [CW-1:0]   run_next;
    logic            raw_hz;
    logic            waw_hz;
    logic            br_hz;
    logic            issue;

    // A result completing this cycle is forwarded, so it never counts as busy.
    always_comb begin
        fwd_mask = '0;
        if (done_valid && done_rd != '0) fwd_mask[done_rd] = 1'b1;
        busy = pend & ~fwd_mask & R0_MASK;
    end

    always_comb begin
        raw_hz = (id_use_rs1 && busy[id_rs1]) || (id_use_rs2 && busy[id_rs2]);
        waw_hz = WAW_EN && id_regwrite && busy[id_rd];
        br_hz  = id_branch && ex_regwrite && (ex_rd != '0) &&
                 ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
        hz     = id_valid && !flush && !Rst && (raw_hz || waw_hz || br_hz);
        issue  = id_valid && !hz && !flush;
    end

    // Set is applied after clear so a newer producer wins on the same index.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue && id_regwrite && id_long && id_rd != '0) set_mask[id_rd] = 1'b1;
        if (done_valid) clr_mask[done_rd] = 1'b1;
        pend_next = ((pend & ~clr_mask) | set_mask) & R0_MASK;
    end

    always_comb begin
        run_next = '0;
        if (hz) run_next = (run == CNT_MAX) ? run : run + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            pend        <= '0;
            run         <= '0;
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            pend <= pend_next;
            run  <= run_next;
            if (hz && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CW'(1);
            if (run_next == TO_VAL) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (WAW on / default sizes, and WAW off
// with a 4-bit counter and TIMEOUT=8) checked against a rule-level scoreboard model.
module tb_hazard_scoreboard;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int CW0  = 16;
    localparam int TO0  = 1024;
    localparam int CW1  = 4;
    localparam int TO1  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_long, id_branch;
    logic [AW-1:0] id_rs1, id_rs2, id_rd, ex_rd, done_rd;
    logic          ex_regwrite, done_valid, flush;
    logic          hz0, hz1, err0, err1;
    logic [CW0-1:0] cnt0;
    logic [CW1-1:0] cnt1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one entry per instance (0 = WAW on, 1 = WAW off/small).
    bit m_pend [2][NREG];
    int m_run  [2];
    int m_cnt  [2];
    bit m_err  [2];

    always #5 clk = ~clk;

    hazard_scoreboard #(.NREG(NREG), .AW(AW), .WAW_EN(1'b1), .CW(CW0), .TIMEOUT(TO0)) dut (
        .clk(clk), .Rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_long(id_long), .id_branch(id_branch),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .done_valid(done_valid),
        .done_rd(done_rd), .flush(flush), .hz(hz0), .stall_cnt(cnt0), .timeout_err(err0)
    );

    hazard_scoreboard #(.NREG(NREG), .AW(AW), .WAW_EN(1'b0), .CW(CW1), .TIMEOUT(TO1)) dut_s (
        .clk(clk), .Rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_long(id_long), .id_branch(id_branch),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .done_valid(done_valid),
        .done_rd(done_rd), .flush(flush), .hz(hz1), .stall_cnt(cnt1), .timeout_err(err1)
    );

    function automatic bit m_busy(int k, int r);
        return (r != 0) && m_pend[k][r] && !(done_valid && int'(done_rd) == r);
    endfunction

    function automatic bit model_hz(int k);
        bit raw, waw, br;
        if (rst || !id_valid || flush) return 1'b0;
        raw = (id_use_rs1 && m_busy(k, int'(id_rs1))) || (id_use_rs2 && m_busy(k, int'(id_rs2)));
        waw = (k == 0) && id_regwrite && m_busy(k, int'(id_rd));
        br  = id_branch && ex_regwrite && ex_rd != 0 &&
              ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
        return raw || waw || br;
    endfunction

    // Advance one clock and apply the scoreboard rules to the model.
    task automatic tick();
        bit e [2];
        int cmax, to;
        for (int k = 0; k < 2; k++) e[k] = model_hz(k);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            cmax = (k == 0) ? (1 << CW0) - 1 : (1 << CW1) - 1;
            to   = (k == 0) ? TO0 : TO1;
            if (rst) begin
                for (int r = 0; r < NREG; r++) m_pend[k][r] = 1'b0;
                m_run[k] = 0; m_cnt[k] = 0; m_err[k] = 1'b0;
            end else begin
                if (done_valid) m_pend[k][done_rd] = 1'b0;
                if (id_valid && !e[k] && !flush && id_regwrite && id_long && id_rd != 0)
                    m_pend[k][id_rd] = 1'b1;
                if (e[k] && m_cnt[k] < cmax) m_cnt[k]++;
                m_run[k] = e[k] ? ((m_run[k] < cmax) ? m_run[k] + 1 : m_run[k]) : 0;
                if (m_run[k] == to) m_err[k] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_regwrite = 0; id_long = 0;
        id_branch = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; ex_rd = 0; ex_regwrite = 0;
        done_valid = 0; done_rd = 0; flush = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic issue_load(input logic [AW-1:0] rd);
        clear_inputs();
        id_valid = 1; id_regwrite = 1; id_long = 1; id_rd = rd;
        tick();
    endtask

    task automatic read_rs1(input logic [AW-1:0] r);
        clear_inputs();
        id_valid = 1; id_use_rs1 = 1; id_rs1 = r;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        id_valid = 1; id_branch = 1; ex_regwrite = 1; ex_rd = 3; id_use_rs1 = 1; id_rs1 = 3;
        @(negedge clk);
        n_checks++; if (hz0 !== 1'b0) $display("FAIL reset_hz_in_rst hz=%0b exp=0", hz0); else n_pass++;
        tick(); rst = 0; clear_inputs();
        @(negedge clk);
        n_checks++; if (cnt0 !== '0) $display("FAIL reset_cnt0 got=%0d exp=0", cnt0); else n_pass++;
        n_checks++; if (cnt1 !== '0) $display("FAIL reset_cnt1 got=%0d exp=0", cnt1); else n_pass++;
        n_checks++; if (err0 !== 1'b0 || err1 !== 1'b0) $display("FAIL reset_err got=%0b%0b exp=00", err0, err1); else n_pass++;
        n_checks++; if (hz0 !== 1'b0 || hz1 !== 1'b0) $display("FAIL reset_hz got=%0b%0b exp=00", hz0, hz1); else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        issue_load(5);
        read_rs1(5);
        @(negedge clk);
        n_checks++; if (hz0 !== 1'b1) $display("FAIL load_use_stall hz=%0b exp=1", hz0); else n_pass++;
        tick();
        done_valid = 1; done_rd = 5;
        @(negedge clk);
        n_checks++; if (hz0 !== 1'b0) $display("FAIL load_use_release hz=%0b exp=0", hz0); else n_pass++;
        tick();
        read_rs1(5);
        @(negedge clk);
        n_checks++; if (hz0 !== 1'b0) $display("FAIL load_use_pend_cleared hz=%0b exp=0", hz0); else n_pass++;
        n_checks++; if (cnt0 !== 16'd1) $display("FAIL load_use_stall_cnt got=%0d exp=1", cnt0); else n_pass++;
        tick();
    endtask

    task automatic test_forward();
        do_reset();
        issue_load(7);
        read_rs1(7); done_valid = 1; done_rd = 7;
        @(negedge clk);
        n_checks++; if (hz0 !== 1'b0) $display("FAIL same_cycle_fwd hz=%0b exp=0", hz0); else n_pass++;
        tick();
        // x0 as long destination must never become pending
        issue_load(0);
        clear_inputs();
        id_valid = 1; id_use_rs1 = 1; id_use_rs2 = 1; id_regwrite = 1; id_rd = 0;
        id_branch = 1; ex_regwrite = 1; ex_rd = 0;
        @(negedge clk);
        n_checks++; if (hz0 !== 1'b0 || hz1 !== 1'b0) $display("FAIL x0_no_stall hz=%0b%0b exp=00", hz0, hz1); else n_pass++;
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        clear_inputs();
        id_valid = 1; id_branch = 1; id_use_rs1 = 1; id_use_rs2 = 1; id_rs1 = 1; id_rs2 = 3;
        ex_regwrite = 1; ex_rd = 3;
        @(negedge clk);
        n_checks++; if (hz0 !== 1'b1) $display("FAIL branch_stall hz=%0b exp=1", hz0); else n_pass++;
        tick();
        ex_regwrite = 0;
        @(negedge clk);
        n_checks++; if (hz0 !== 1'b0) $display("FAIL branch_one_cycle hz=%0b exp=0", hz0); else n_pass++;
        tick();
        id_branch = 0; ex_regwrite = 1; ex_rd = 3;
        @(negedge clk);
        n_checks++; if (hz0 !== 1'b0) $display("FAIL nonbranch_ex hz=%0b exp=0", hz0); else n_pass++;
        tick();
    endtask

    task automatic test_waw();
        do_reset();
        issue_load(9);
        clear_inputs();
        id_valid = 1; id_regwrite = 1; id_rd = 9;
        @(negedge clk);
        n_checks++; if (hz0 !== 1'b1) $display("FAIL waw_en_stall hz=%0b exp=1", hz0); else n_pass++;
        n_checks++; if (hz1 !== 1'b0) $display("FAIL waw_dis_no_stall hz=%0b exp=0", hz1); else n_pass++;
        tick();
        id_long = 1; done_valid = 1; done_rd = 9;
        @(negedge clk);
        n_checks++; if (hz0 !== 1'b0) $display("FAIL waw_fwd_issue hz=%0b exp=0", hz0); else n_pass++;
        tick();
        read_rs1(9);
        @(negedge clk);
        n_checks++; if (hz0 !== 1'b1 || hz1 !== 1'b1) $display("FAIL set_wins_over_clear hz=%0b%0b exp=11", hz0, hz1); else n_pass++;
        tick();
    endtask

    task automatic test_watchdog();
        do_reset();
        issue_load(4);
        read_rs1(4);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++; if (hz1 !== 1'b1) $display("FAIL wd_hold_stall i=%0d hz=%0b exp=1", i, hz1); else n_pass++;
            n_checks++; if (int'(cnt1) != ((i < 15) ? i : 15)) $display("FAIL wd_cnt_sat i=%0d got=%0d exp=%0d", i, cnt1, (i < 15) ? i : 15); else n_pass++;
            n_checks++; if (err1 !== (i >= 8)) $display("FAIL wd_timeout i=%0d got=%0b exp=%0b", i, err1, (i >= 8)); else n_pass++;
            n_checks++; if (int'(cnt0) != i || err0 !== 1'b0) $display("FAIL wd_wide i=%0d cnt=%0d err=%0b exp=%0d/0", i, cnt0, err0, i); else n_pass++;
            tick();
        end
        done_valid = 1; done_rd = 4;
        @(negedge clk);
        n_checks++; if (hz1 !== 1'b0) $display("FAIL wd_release hz=%0b exp=0", hz1); else n_pass++;
        tick();
        clear_inputs();
        @(negedge clk);
        n_checks++; if (err1 !== 1'b1 || cnt1 !== 4'd15) $display("FAIL wd_sticky err=%0b cnt=%0d exp=1/15", err1, cnt1); else n_pass++;
        tick();
    endtask

    task automatic test_flush_reset();
        do_reset();
        issue_load(6);
        read_rs1(6); flush = 1; id_regwrite = 1; id_long = 1; id_rd = 10;
        @(negedge clk);
        n_checks++; if (hz0 !== 1'b0) $display("FAIL flush_hz hz=%0b exp=0", hz0); else n_pass++;
        tick();
        read_rs1(6);
        @(negedge clk);
        n_checks++; if (hz0 !== 1'b1) $display("FAIL flush_keeps_pend hz=%0b exp=1", hz0); else n_pass++;
        tick();
        clear_inputs();
        id_valid = 1; id_use_rs2 = 1; id_rs2 = 10;
        @(negedge clk);
        n_checks++; if (hz0 !== 1'b0) $display("FAIL flush_no_issue hz=%0b exp=0", hz0); else n_pass++;
        tick();
        read_rs1(6); rst = 1;
        @(negedge clk);
        n_checks++; if (hz0 !== 1'b0) $display("FAIL rst_mid_stall hz=%0b exp=0", hz0); else n_pass++;
        tick();
        rst = 0;
        @(negedge clk);
        n_checks++; if (hz0 !== 1'b0 || cnt0 !== '0 || err0 !== 1'b0) $display("FAIL after_rst hz=%0b cnt=%0d err=%0b exp=0/0/0", hz0, cnt0, err0); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            clear_inputs();
            rst         = ($urandom_range(0, 63) == 0);
            id_valid    = ($urandom_range(0, 3) != 0);
            id_rs1      = AW'($urandom_range(0, 7));
            id_rs2      = AW'($urandom_range(0, 7));
            id_rd       = AW'($urandom_range(0, 7));
            id_use_rs1  = $urandom_range(0, 1);
            id_use_rs2  = $urandom_range(0, 1);
            id_regwrite = $urandom_range(0, 1);
            id_long     = $urandom_range(0, 1);
            id_branch   = ($urandom_range(0, 3) == 0);
            ex_rd       = AW'($urandom_range(0, 7));
            ex_regwrite = $urandom_range(0, 1);
            done_valid  = ($urandom_range(0, 2) == 0);
            done_rd     = AW'($urandom_range(0, 7));
            flush       = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            n_checks++; if (hz0 !== model_hz(0)) $display("FAIL rand_hz0 c=%0d got=%0b exp=%0b", c, hz0, model_hz(0)); else n_pass++;
            n_checks++; if (hz1 !== model_hz(1)) $display("FAIL rand_hz1 c=%0d got=%0b exp=%0b", c, hz1, model_hz(1)); else n_pass++;
            n_checks++; if (int'(cnt0) != m_cnt[0] || int'(cnt1) != m_cnt[1]) $display("FAIL rand_cnt c=%0d got=%0d/%0d exp=%0d/%0d", c, cnt0, cnt1, m_cnt[0], m_cnt[1]); else n_pass++;
            n_checks++; if (err0 !== m_err[0] || err1 !== m_err[1]) $display("FAIL rand_err c=%0d got=%0b%0b exp=%0b%0b", c, err0, err1, m_err[0], m_err[1]); else n_pass++;
            tick();
        end
        rst = 0;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_forward();
        test_branch();
        test_waw();
        test_watchdog();
        test_flush_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=stuck exp=finish");
        $fatal(1, "bench timeout");
    end

endmodule
